// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access size codes, latched request.
package mips_cpu_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Only the fields still needed after acceptance: lane select and extension mode.
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [1:0] size;
        logic       signed_load;
    } req_t;

    function automatic logic access_err(input logic       memread,
                                        input logic       memwrite,
                                        input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic err;
        err = (memread == memwrite);
        case (size)
            SIZE_BYTE: err = err;
            SIZE_HALF: err = err | addr_lo[0];
            SIZE_WORD: err = err | (|addr_lo);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Byte-lane steering: byteenable, store replication, load lane extract and extension.
// Purely combinational, zero latency; no flow control of its own.
// Illegal size yields an all-zero byteenable.
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        signed_load,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = readdata[7:0];
            2'd1:    byte_lane = readdata[15:8];
            2'd2:    byte_lane = readdata[23:16];
            default: byte_lane = readdata[31:24];
        endcase
        half_lane = addr_lo[1] ? readdata[31:16] : readdata[15:0];
    end

    always_comb begin
        byteenable = 4'b0000;
        writedata  = wdata;
        load_data  = readdata;
        case (size)
            SIZE_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                writedata  = {4{wdata[7:0]}};
                load_data  = {{24{signed_load & byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                byteenable = 4'b0011 << addr_lo;
                writedata  = {2{wdata[15:0]}};
                load_data  = {{16{signed_load & half_lane[15]}}, half_lane};
            end
            SIZE_WORD: begin
                byteenable = 4'b1111;
            end
            default: begin
                byteenable = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit bridging the CPU control path to an Avalon-MM master port.
// Latency: 3 cycles request-to-done with no wait states, +1 per waitrequest cycle; errors finish in 2.
// Backpressure: avm_waitrequest holds the bus phase; stall freezes the pipeline meanwhile.
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        signed_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    lsu_state_t state_q;
    req_t       req_q;

    logic        in_idle;
    logic [1:0]  al_size;
    logic [1:0]  al_addr_lo;
    logic        al_signed;
    logic [3:0]  al_byteenable;
    logic [31:0] al_writedata;
    logic [31:0] al_load_data;
    logic        req_err;

    // Lane logic sees the live request while idle and the latched one during the access.
    assign in_idle    = (state_q == ST_IDLE);
    assign al_size    = in_idle ? size        : req_q.size;
    assign al_addr_lo = in_idle ? addr[1:0]   : req_q.addr_lo;
    assign al_signed  = in_idle ? signed_load : req_q.signed_load;
    assign req_err    = access_err(memread, memwrite, size, addr[1:0]);

    mips_cpu_lsu_align u_align (
        .size        (al_size),
        .addr_lo     (al_addr_lo),
        .signed_load (al_signed),
        .wdata       (wdata),
        .readdata    (avm_readdata),
        .byteenable  (al_byteenable),
        .writedata   (al_writedata),
        .load_data   (al_load_data)
    );

    assign stall = (in_idle && req_valid) || (state_q == ST_READ) || (state_q == ST_WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            done           <= 1'b0;
            addr_err       <= 1'b0;
            rdata          <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'b0000;
            avm_writedata  <= '0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q.addr_lo     <= addr[1:0];
                        req_q.size        <= size;
                        req_q.signed_load <= signed_load;
                        avm_address       <= {addr[31:2], 2'b00};
                        avm_writedata     <= al_writedata;
                        if (req_err) begin
                            avm_byteenable <= 4'b0000;
                            done           <= 1'b1;
                            addr_err       <= 1'b1;
                            state_q        <= ST_RESP;
                        end else if (memread) begin
                            avm_byteenable <= al_byteenable;
                            avm_read       <= 1'b1;
                            state_q        <= ST_READ;
                        end else begin
                            avm_byteenable <= al_byteenable;
                            avm_write      <= 1'b1;
                            state_q        <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (!avm_waitrequest) begin
                        rdata    <= al_load_data;
                        avm_read <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu: directed vectors plus randomized accesses vs a byte-level model.
module tb_mips_cpu_lsu;
    import mips_cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        signed_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] ref_rdata;

    typedef struct {
        int          done_cyc;
        bit          err;
        bit          bus_rd;
        bit          bus_wr;
        bit          both;
        bit          unstable;
        bit          stall_bad;
        logic [31:0] address;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] rdata;
    } obs_t;

    mips_cpu_lsu dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .memread         (memread),
        .memwrite        (memwrite),
        .size            (size),
        .signed_load     (signed_load),
        .addr            (addr),
        .wdata           (wdata),
        .stall           (stall),
        .done            (done),
        .rdata           (rdata),
        .addr_err        (addr_err),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    // Reference model: accesses viewed as a run of little-endian bytes.
    function automatic int nbytes_of(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        if (sz == 2'b10) return 4;
        return 0;
    endfunction

    function automatic bit model_err(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = nbytes_of(sz);
        if (n == 0 || rd == wr) return 1'b1;
        return (int'(a[1:0]) % n) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int lo;
        be = 4'b0000;
        lo = int'(a[1:0]);
        for (int i = 0; i < nbytes_of(sz); i++) be[lo + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes_of(sz);
        for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = wd[8*(lane % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] sz, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] rdv);
        longint v;
        int n;
        int lo;
        n  = nbytes_of(sz);
        lo = int'(a[1:0]);
        v  = 0;
        for (int i = 0; i < n; i++) v += longint'(rdv[8*(lo + i) +: 8]) << (8*i);
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    // Issues one request, acts as the bus slave, and records what the DUT did.
    task automatic drive_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                                input int nwait, output obs_t o);
        int waited;
        bit seen;
        o.done_cyc = -1; o.err = 0; o.bus_rd = 0; o.bus_wr = 0; o.both = 0;
        o.unstable = 0; o.stall_bad = 0; o.address = '0; o.be = '0; o.wdat = '0; o.rdata = '0;
        waited = 0;
        seen   = 0;
        memread = rd; memwrite = wr; size = sz; signed_load = sgn; addr = a; wdata = wd;
        req_valid = 1'b1; avm_waitrequest = 1'b1; avm_readdata = $urandom;
        #1;
        if (stall !== 1'b1) o.stall_bad = 1;
        for (int cyc = 2; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (avm_read === 1'b1 && avm_write === 1'b1) o.both = 1;
            if (avm_read === 1'b1 || avm_write === 1'b1) begin
                if (!seen) begin
                    seen = 1; o.bus_rd = avm_read; o.bus_wr = avm_write;
                    o.address = avm_address; o.be = avm_byteenable; o.wdat = avm_writedata;
                end else if (avm_read !== o.bus_rd || avm_write !== o.bus_wr || avm_address !== o.address ||
                             avm_byteenable !== o.be || avm_writedata !== o.wdat) begin
                    o.unstable = 1;
                end
                if (waited < nwait) begin
                    avm_waitrequest = 1'b1; avm_readdata = $urandom; waited++;
                end else begin
                    avm_waitrequest = 1'b0; avm_readdata = rdv;
                end
            end else begin
                avm_waitrequest = 1'($urandom); avm_readdata = $urandom;
            end
            if (done === 1'b1) begin
                o.done_cyc = cyc; o.err = addr_err; o.rdata = rdata;
                if (stall !== 1'b0) o.stall_bad = 1;
                break;
            end else if (stall !== 1'b1) begin
                o.stall_bad = 1;
            end
        end
        req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({stall, done, addr_err, avm_read, avm_write} !== 5'b0 || rdata !== 32'h0 || avm_byteenable !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_state: stall=%b done=%b err=%b rd=%b wr=%b rdata=%h be=%b, required all zero",
                     stall, done, addr_err, avm_read, avm_write, rdata, avm_byteenable);
        end
        reset = 1'b0;
        ref_rdata = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb_signed();
        obs_t o;
        drive_access(1, 0, SIZE_BYTE, 1, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, o);
        ref_rdata = 32'hFFFF_FF80;
        n_checks++;
        if (o.be !== 4'b1000 || !o.bus_rd || o.address !== 32'h1000) begin
            n_errors++;
            $display("FAIL lb_bus: rd=%b addr=%h be=%b, required rd=1 addr=00001000 be=1000", o.bus_rd, o.address, o.be);
        end
        n_checks++;
        if (o.rdata !== 32'hFFFF_FF80 || o.done_cyc != 3 || o.err) begin
            n_errors++;
            $display("FAIL lb_result: rdata=%h done_cyc=%0d err=%b, required FFFFFF80 at 3 err=0", o.rdata, o.done_cyc, o.err);
        end
    endtask

    task automatic test_lhu_wait();
        obs_t o;
        drive_access(1, 0, SIZE_HALF, 0, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3, o);
        ref_rdata = 32'h0000_BEEF;
        n_checks++;
        if (o.unstable || o.be !== 4'b1100 || o.address !== 32'h2000) begin
            n_errors++;
            $display("FAIL lhu_hold: unstable=%b be=%b addr=%h, required stable be=1100 addr=00002000", o.unstable, o.be, o.address);
        end
        n_checks++;
        if (o.rdata !== 32'h0000_BEEF || o.done_cyc != 6) begin
            n_errors++;
            $display("FAIL lhu_result: rdata=%h done_cyc=%0d, required 0000BEEF at 6", o.rdata, o.done_cyc);
        end
    endtask

    task automatic test_sb();
        obs_t o;
        drive_access(0, 1, SIZE_BYTE, 0, 32'h0000_0011, 32'h0000_00AB, 32'h0, 0, o);
        n_checks++;
        if (!o.bus_wr || o.bus_rd || o.address !== 32'h10 || o.be !== 4'b0010 || o.wdat !== 32'hABAB_ABAB) begin
            n_errors++;
            $display("FAIL sb_bus: wr=%b rd=%b addr=%h be=%b wd=%h, required wr=1 rd=0 00000010 0010 ABABABAB",
                     o.bus_wr, o.bus_rd, o.address, o.be, o.wdat);
        end
        n_checks++;
        if (o.done_cyc != 3 || o.rdata !== ref_rdata) begin
            n_errors++;
            $display("FAIL sb_done: done_cyc=%0d rdata=%h, required 3 and %h", o.done_cyc, o.rdata, ref_rdata);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        drive_access(1, 0, SIZE_WORD, 0, 32'h0000_0006, 32'h0, 32'h1234_5678, 0, o);
        n_checks++;
        if (o.bus_rd || o.bus_wr || !o.err || o.done_cyc != 2 || o.rdata !== ref_rdata) begin
            n_errors++;
            $display("FAIL lw_misaligned: rd=%b wr=%b err=%b done_cyc=%0d rdata=%h, required no bus, err=1 at 2, rdata=%h",
                     o.bus_rd, o.bus_wr, o.err, o.done_cyc, o.rdata, ref_rdata);
        end
        n_checks++;
        if (addr_err !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL err_pulse_width: addr_err=%b done=%b one cycle later, required 0 0", addr_err, done);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   resumed;
        memread = 1'b1; memwrite = 1'b0; size = SIZE_WORD; signed_load = 1'b0; addr = 32'h40;
        req_valid = 1'b1; avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (avm_read !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_start: avm_read=%b, required 1", avm_read);
        end
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (avm_read !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || avm_byteenable !== 4'h0) begin
            n_errors++;
            $display("FAIL rst_mid_abort: rd=%b done=%b stall=%b rdata=%h be=%b, required all zero",
                     avm_read, done, stall, rdata, avm_byteenable);
        end
        reset = 1'b0; avm_waitrequest = 1'b0; memread = 1'b0;
        ref_rdata = 32'h0;
        resumed = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (avm_read !== 1'b0 || done !== 1'b0) resumed = 1;
        end
        n_checks++;
        if (resumed) begin
            n_errors++;
            $display("FAIL rst_mid_resume: bus or done activity after reset, required none");
        end
        drive_access(1, 0, SIZE_WORD, 0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1, o);
        ref_rdata = 32'hCAFE_F00D;
        n_checks++;
        if (o.rdata !== 32'hCAFE_F00D || o.done_cyc != 4 || o.err) begin
            n_errors++;
            $display("FAIL rst_mid_new: rdata=%h done_cyc=%0d err=%b, required CAFEF00D at 4 err=0", o.rdata, o.done_cyc, o.err);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        logic [31:0] a;
        logic [31:0] wd;
        a  = {$urandom} & 32'hFFFF_FFFC;
        wd = $urandom;
        drive_access(0, 1, SIZE_WORD, 0, a, wd, 32'h0, 0, o1);
        drive_access(1, 0, SIZE_WORD, 0, a, 32'h0, wd, 0, o2);
        ref_rdata = wd;
        n_checks++;
        if (o1.done_cyc != 3 || o2.done_cyc != 3 || o1.wdat !== wd || o2.address !== o1.address) begin
            n_errors++;
            $display("FAIL b2b_latency: sw_cyc=%0d lw_cyc=%0d wd=%h addr=%h/%h, required 3 3 %h same",
                     o1.done_cyc, o2.done_cyc, o1.wdat, o1.address, o2.address, wd);
        end
        n_checks++;
        if (o1.stall_bad || o2.stall_bad || o2.rdata !== wd) begin
            n_errors++;
            $display("FAIL b2b_stall: stall_bad=%b/%b rdata=%h, required 0/0 %h", o1.stall_bad, o2.stall_bad, o2.rdata, wd);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int it = 0; it < 60; it++) begin
            bit          rd;
            bit          wr;
            bit          sgn;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rdv;
            int          k;
            int          nwait;
            bit          err;
            int          exp_cyc;
            k  = $urandom_range(0, 9);
            rd = (k < 4) || (k == 8);
            wr = (k >= 4 && k < 8) || (k == 8);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SIZE_HALF) a[0] = 1'b0;
                if (sz == SIZE_WORD) a[1:0] = 2'b00;
            end
            sgn   = 1'($urandom);
            wd    = $urandom;
            rdv   = $urandom;
            nwait = $urandom_range(0, 3);
            err   = model_err(rd, wr, sz, a);
            exp_cyc = err ? 2 : 3 + nwait;
            drive_access(rd, wr, sz, sgn, a, wd, rdv, nwait, o);
            if (!err && rd) ref_rdata = model_ld(sz, sgn, a, rdv);
            n_checks++;
            if (o.err != err || o.done_cyc != exp_cyc) begin
                n_errors++;
                $display("FAIL rand_done[%0d]: err=%b cyc=%0d, required err=%b cyc=%0d", it, o.err, o.done_cyc, err, exp_cyc);
            end
            n_checks++;
            if (o.rdata !== ref_rdata) begin
                n_errors++;
                $display("FAIL rand_rdata[%0d]: rdata=%h, required %h", it, o.rdata, ref_rdata);
            end
            n_checks++;
            if (o.both || o.unstable || o.stall_bad) begin
                n_errors++;
                $display("FAIL rand_proto[%0d]: both=%b unstable=%b stall_bad=%b, required 0 0 0", it, o.both, o.unstable, o.stall_bad);
            end
            n_checks++;
            if (err) begin
                if (o.bus_rd || o.bus_wr) begin
                    n_errors++;
                    $display("FAIL rand_errbus[%0d]: rd=%b wr=%b, required no bus access", it, o.bus_rd, o.bus_wr);
                end
            end else if (o.bus_rd != rd || o.bus_wr != wr || o.address !== {a[31:2], 2'b00} ||
                         o.be !== model_be(sz, a) || (wr && o.wdat !== model_wd(sz, wd))) begin
                n_errors++;
                $display("FAIL rand_bus[%0d]: rd=%b wr=%b addr=%h be=%b wd=%h, required %b %b %h %b %h",
                         it, o.bus_rd, o.bus_wr, o.address, o.be, o.wdat, rd, wr, {a[31:2], 2'b00},
                         model_be(sz, a), model_wd(sz, wd));
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; size = 2'b00;
        signed_load = 1'b0; addr = '0; wdata = '0; avm_readdata = '0; avm_waitrequest = 1'b0;
        ref_rdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_lb_signed();
        test_lhu_wait();
        test_sb();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
